// File: rtl/tb_dii_seq_if.sv
// ---------------------------------------------------------------------------
// tb_dii_seq_if
//   Bundles the harness-facing (loader/start) and core-facing (DII) signals
//   of the DII sequencer so they travel as one port.
//
//   Parameter:
//     AW  stream index width (must match the sequencer's AW)
//
//   Signals (named from the sequencer's point of view):
//     load_we_i / load_addr_i / load_data_i  stream buffer write port
//     stream_len_i                           words in the stream, 0..2**AW
//     start_i                                single-cycle run request
//     dii_ack_i                              core consumed dii_insn_o
//     dii_insn_o                             instruction presented to the core
//     core_rstn_o                            active-low reset to the core
//     busy_o / done_o                        run status
//     insn_cnt_o                             instructions acknowledged this run
//     timeout_o                              ack watchdog fired
//
//   Modports:
//     master  harness side (drives loads, start and ack)
//     slave   sequencer side
// ---------------------------------------------------------------------------
interface tb_dii_seq_if #(
  parameter int AW = 16
);
  logic          load_we_i;
  logic [AW-1:0] load_addr_i;
  logic [31:0]   load_data_i;
  logic [AW:0]   stream_len_i;
  logic          start_i;
  logic          dii_ack_i;
  logic [31:0]   dii_insn_o;
  logic          core_rstn_o;
  logic          busy_o;
  logic          done_o;
  logic [AW:0]   insn_cnt_o;
  logic          timeout_o;

  modport master (
    output load_we_i, load_addr_i, load_data_i, stream_len_i, start_i, dii_ack_i,
    input  dii_insn_o, core_rstn_o, busy_o, done_o, insn_cnt_o, timeout_o
  );

  modport slave (
    input  load_we_i, load_addr_i, load_data_i, stream_len_i, start_i, dii_ack_i,
    output dii_insn_o, core_rstn_o, busy_o, done_o, insn_cnt_o, timeout_o
  );
endinterface

// File: rtl/tb_dii_seq.sv
// ---------------------------------------------------------------------------
// tb_dii_seq
//   Sequencer for the direct-instruction-injection path of the CHERIoT test
//   top. It holds a pre-loaded instruction stream, holds the core in reset for
//   RST_HOLD cycles after a start, presents one instruction per core ack,
//   then feeds NOPs for DRAIN_CYCLES cycles and flags completion.
//
//   Run flow: IDLE -> RST_HOLD -> STREAM -> DRAIN -> DONE -> (start) RST_HOLD
//   (RST_HOLD goes straight to DRAIN when the stream is empty.)
//
//   Parameters:
//     AW            stream index width; buffer depth 2**AW words
//     NOP_INSN      instruction driven when no stream word is valid
//     RST_HOLD      cycles core_rstn_o is held low after start (>=1)
//     DRAIN_CYCLES  NOP cycles after the last instruction before done (>=1)
//     TIMEOUT       ack watchdog limit in cycles (watchdog builds only)
//
//   Ports:
//     clk_i   clock
//     rstn_i  asynchronous active-low reset
//     bus     tb_dii_seq_if.slave: loader, start, DII handshake and status
//
//   Build option:
//     DII_SEQ_TIMEOUT_EN  when defined, a watchdog aborts STREAM after
//                         TIMEOUT consecutive cycles with no ack, sets the
//                         sticky timeout_o and drains. When undefined,
//                         STREAM waits forever and timeout_o is tied 0.
// ---------------------------------------------------------------------------
module tb_dii_seq #(
  parameter int          AW           = 16,
  parameter logic [31:0] NOP_INSN     = 32'h1,
  parameter int          RST_HOLD     = 10,
  parameter int          DRAIN_CYCLES = 10,
  parameter int          TIMEOUT      = 4096
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  tb_dii_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  // One counter serves both the reset-hold and the drain phases.
  localparam int HOLD_MAX = (RST_HOLD > DRAIN_CYCLES) ? RST_HOLD : DRAIN_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [HW-1:0] DRAIN_LAST = HW'(DRAIN_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};

`ifdef DII_SEQ_TIMEOUT_EN
  localparam int            WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
`endif

  // Stream buffer.
  logic [31:0] mem [2**AW];
  logic        mem_we;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   cnt_inc;
  logic [31:0]   insn_q, insn_d;
  logic          core_rstn_q, core_rstn_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef DII_SEQ_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  assign cnt_inc = cnt_q + CNT_ONE;

  // NOTE: every variable is given its hold value before the case statement so
  // no path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    insn_d      = insn_q;
    core_rstn_d = core_rstn_q;
    done_d      = done_q;
    mem_we      = 1'b0;
`ifdef DII_SEQ_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // The buffer is only writable between runs.
        mem_we = bus.load_we_i;
        if (bus.start_i) begin
          state_d     = S_RST_HOLD;
          hold_d      = '0;
          len_d       = bus.stream_len_i;
          cnt_d       = '0;
          done_d      = 1'b0;
          core_rstn_d = 1'b0;
          // First word is staged during the hold so it is ready at release.
          insn_d      = (bus.stream_len_i == '0) ? NOP_INSN : mem[0];
`ifdef DII_SEQ_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end

      S_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          core_rstn_d = 1'b1;
          hold_d      = '0;
          state_d     = (len_q != '0) ? S_STREAM : S_DRAIN;
`ifdef DII_SEQ_TIMEOUT_EN
          wd_d        = '0;
`endif
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      S_STREAM: begin
        if (bus.dii_ack_i) begin
          cnt_d = cnt_inc;
`ifdef DII_SEQ_TIMEOUT_EN
          wd_d  = '0;
`endif
          if (cnt_inc < len_q) begin
            insn_d = mem[cnt_inc[AW-1:0]];
          end else begin
            insn_d  = NOP_INSN;
            hold_d  = '0;
            state_d = S_DRAIN;
          end
        end
`ifdef DII_SEQ_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          // Core stalled: abandon the rest of the stream, count stays frozen.
          timeout_d = 1'b1;
          insn_d    = NOP_INSN;
          hold_d    = '0;
          state_d   = S_DRAIN;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
`endif
      end

      S_DRAIN: begin
        // Acks are deliberately ignored here; the core is only fed NOPs.
        insn_d = NOP_INSN;
        if (hold_q == DRAIN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RST_HOLD) || (state_d == S_STREAM) || (state_d == S_DRAIN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      insn_q      <= NOP_INSN;
      core_rstn_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DII_SEQ_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      insn_q      <= insn_d;
      core_rstn_q <= core_rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DII_SEQ_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // NOTE: the buffer has no reset; its contents are only meaningful after the
  // harness loads it, and a reset branch would prevent RAM inference.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[bus.load_addr_i] <= bus.load_data_i;
    end
  end

  assign bus.dii_insn_o  = insn_q;
  assign bus.core_rstn_o = core_rstn_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.insn_cnt_o  = cnt_q;
`ifdef DII_SEQ_TIMEOUT_EN
  assign bus.timeout_o   = timeout_q;
`else
  assign bus.timeout_o   = 1'b0;
`endif

endmodule
